hall_conditioner: RTL

Upstream conditioning stage for the motor driver's Hall inputs; one instance per motor.
- Synchronizes and debounces raw Hall sensor lines.
- Rejects illegal codes and checks commutation sequence legality.
- Reports rotation direction and the commutation period in clock cycles.
- Filtered code feeds the driver's Hall input; period/direction feed the speed loop.

---
 rtl/hall_conditioner.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hall_conditioner.sv
// Hall sensor front end: synchronize, debounce, legality/sequence checks,
// direction and commutation-period measurement with stall detection.
module hall_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIOD_WIDTH    = 16,
    parameter int unsigned STALL_LIMIT     = 65535
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [2:0]              hall_raw,
    input  logic                    fault_clear,
    output logic [2:0]              hall_out,
    output logic                    hall_valid,
    output logic                    direction,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_strobe,
    output logic                    stalled,
    output logic                    fault
);

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]         DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_WIDTH-1:0] CNT_STALL = PERIOD_WIDTH'(STALL_LIMIT);

    typedef enum logic [1:0] {ST_INIT, ST_SYNCED, ST_RUN, ST_STALL} state_t;

    state_t                  state, state_d;
    logic [2:0]              sync1, hall_sync;
    logic [2:0]              cand;
    logic [DB_W-1:0]         db_cnt, db_cnt_d;
    logic [2:0]              acc_code;
    logic [PERIOD_WIDTH-1:0] period_cnt, period_cnt_d;

    logic [2:0]              hall_out_d;
    logic                    hall_valid_d, direction_d, strobe_d, stalled_d, fault_d;
    logic [PERIOD_WIDTH-1:0] period_d;

    logic accept_c, code_legal_c, step_fwd_c, step_rev_c, timeout_c;
    logic evt_illegal_c, evt_legal_c, evt_step_c, evt_skip_c, evt_first_c;

    // Successor of a legal code in the forward commutation order.
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        case (code)
            3'b001:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b101;
            3'b101:  fwd_next = 3'b001;
            default: fwd_next = 3'b000;
        endcase
    endfunction

    // Acceptance fires on the edge where the count reaches its final value, so a
    // clean step appears on hall_out 2+DEBOUNCE_CYCLES clocks after first sampling.
    always_comb begin
        db_cnt_d = db_cnt;
        if (hall_sync != cand)
            db_cnt_d = '0;
        else if (db_cnt != DB_MAX)
            db_cnt_d = db_cnt + DB_W'(1);
    end

    assign accept_c      = (db_cnt_d == DB_MAX) && (hall_sync != acc_code);
    assign code_legal_c  = (hall_sync != 3'b000) && (hall_sync != 3'b111);
    assign step_fwd_c    = (hall_sync == fwd_next(hall_out));
    assign step_rev_c    = (fwd_next(hall_sync) == hall_out);
    assign timeout_c     = (period_cnt == CNT_STALL);

    assign evt_illegal_c = accept_c && !code_legal_c;
    assign evt_legal_c   = accept_c && code_legal_c && (!hall_valid || hall_sync != hall_out);
    assign evt_first_c   = evt_legal_c && !hall_valid;
    assign evt_step_c    = evt_legal_c && hall_valid && (step_fwd_c || step_rev_c);
    assign evt_skip_c    = evt_legal_c && hall_valid && !(step_fwd_c || step_rev_c);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_d;
    end

    // A skip discards the timing reference; the next legal step only re-arms it.
    always_comb begin
        state_d = state;
        case (state)
            ST_INIT: begin
                if (evt_first_c || evt_step_c) state_d = ST_SYNCED;
            end
            ST_SYNCED, ST_RUN: begin
                if (evt_step_c)      state_d = ST_RUN;
                else if (evt_skip_c) state_d = ST_INIT;
                else if (timeout_c)  state_d = ST_STALL;
            end
            ST_STALL: begin
                if (evt_step_c)      state_d = ST_SYNCED;
                else if (evt_skip_c) state_d = ST_INIT;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        hall_out_d   = hall_out;
        hall_valid_d = hall_valid;
        direction_d  = direction;
        period_d     = period;
        strobe_d     = 1'b0;
        period_cnt_d = period_cnt;
        fault_d      = fault;

        if (evt_legal_c) begin
            hall_out_d   = hall_sync;
            hall_valid_d = 1'b1;
            period_cnt_d = '0;
        end else if (state != ST_INIT && period_cnt != CNT_MAX) begin
            period_cnt_d = period_cnt + PERIOD_WIDTH'(1);
        end

        if (evt_step_c)
            direction_d = step_fwd_c;

        if (evt_step_c && (state == ST_SYNCED || state == ST_RUN)) begin
            period_d = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + PERIOD_WIDTH'(1);
            strobe_d = 1'b1;
        end

        if (state_d == ST_STALL)
            period_d = CNT_MAX;
        stalled_d = (state_d == ST_STALL);

        // A new fault outranks a coincident clear request.
        if (evt_illegal_c || evt_skip_c)
            fault_d = 1'b1;
        else if (fault_clear)
            fault_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 3'b000;
            hall_sync     <= 3'b000;
            cand          <= 3'b000;
            db_cnt        <= '0;
            acc_code      <= 3'b000;
            period_cnt    <= '0;
            hall_out      <= 3'b000;
            hall_valid    <= 1'b0;
            direction     <= 1'b1;
            period        <= '0;
            period_strobe <= 1'b0;
            stalled       <= 1'b0;
            fault         <= 1'b0;
        end else begin
            sync1         <= hall_raw;
            hall_sync     <= sync1;
            cand          <= hall_sync;
            db_cnt        <= db_cnt_d;
            if (accept_c)
                acc_code  <= hall_sync;
            period_cnt    <= period_cnt_d;
            hall_out      <= hall_out_d;
            hall_valid    <= hall_valid_d;
            direction     <= direction_d;
            period        <= period_d;
            period_strobe <= strobe_d;
            stalled       <= stalled_d;
            fault         <= fault_d;
        end
    end

endmodule
